// File: rtl/ram_seq_ctrl.sv
// Request sequencer for an array of ram1x4 words: valid/ready request in, one response out.
// Optional write read-back check is enabled by defining RAM_WRITE_VERIFY_EN.
module ram_seq_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_data,
    output logic             rsp_valid,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_err,
    output logic [DEPTH-1:0] mem_sel,
    output logic             mem_rw,
    output logic             mem_we,
    output logic [DW-1:0]    mem_din,
    input  logic [DW-1:0]    mem_dout,
    output logic             mem_clr
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_VERIFY,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t           r_state;
    logic             r_wr;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_data;

    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [DW-1:0]    r_rsp_data;
    logic             r_rsp_err;
    logic [DEPTH-1:0] r_mem_sel;
    logic             r_mem_rw;
    logic             r_mem_we;
    logic [DW-1:0]    r_mem_din;
    logic             r_mem_clr;

    state_t           w_next;
    logic             w_accept;
    logic             w_wr;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_data;
    logic             w_in_range;
    logic [DEPTH-1:0] w_onehot;
    logic             w_req_ready;
    logic             w_rsp_valid;
    logic [DW-1:0]    w_rsp_data;
    logic             w_rsp_err;
    logic [DEPTH-1:0] w_mem_sel;
    logic             w_mem_rw;
    logic             w_mem_we;
    logic [DW-1:0]    w_mem_din;
    logic             w_mem_clr;

    // The accepting cycle uses the live request; later cycles use the latched copy.
    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_wr       = w_accept ? req_wr   : r_wr;
    assign w_addr     = w_accept ? req_addr : r_addr;
    assign w_data     = w_accept ? req_data : r_data;
    assign w_in_range = ({1'b0, w_addr} < DEPTH_L);
    assign w_onehot   = DEPTH'(1) << w_addr;

    always_comb begin
        w_next     = r_state;
        w_rsp_data = r_rsp_data;
        w_rsp_err  = r_rsp_err;
        case (r_state)
            S_INIT:   w_next = S_IDLE;
            S_IDLE: begin
                if (w_accept) begin
                    if (w_in_range) begin
                        w_next = S_SETUP;
                    end else begin
                        w_next     = S_DONE;
                        w_rsp_data = '0;
                        w_rsp_err  = 1'b1;
                    end
                end
            end
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: begin
                w_next     = S_DONE;
                w_rsp_err  = 1'b0;
                w_rsp_data = r_wr ? '0 : mem_dout;
`ifdef RAM_WRITE_VERIFY_EN
                if (r_wr) begin
                    w_next = S_VERIFY;
                end
`endif
            end
            S_VERIFY: begin
                w_next     = S_DONE;
                w_rsp_err  = (mem_dout != r_data);
                w_rsp_data = (mem_dout != r_data) ? mem_dout : '0;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_INIT;
        endcase
    end

    // Outputs are decoded from the next state so that every port is a flop.
    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_mem_sel   = '0;
        w_mem_rw    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_din   = '0;
        w_mem_clr   = 1'b0;
        case (w_next)
            S_INIT:   w_mem_clr = 1'b1;
            S_IDLE:   w_req_ready = 1'b1;
            S_SETUP: begin
                w_mem_sel = w_onehot;
                w_mem_rw  = w_wr;
                w_mem_din = w_data;
            end
            S_STROBE: begin
                w_mem_sel = w_onehot;
                w_mem_rw  = w_wr;
                w_mem_din = w_data;
                w_mem_we  = w_wr;
            end
            S_VERIFY: begin
                w_mem_sel = w_onehot;
                w_mem_din = w_data;
            end
            S_DONE:   w_rsp_valid = 1'b1;
            default:  w_mem_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= S_INIT;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_sel   <= '0;
            r_mem_rw    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_din   <= '0;
            r_mem_clr   <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
            r_mem_sel   <= w_mem_sel;
            r_mem_rw    <= w_mem_rw;
            r_mem_we    <= w_mem_we;
            r_mem_din   <= w_mem_din;
            r_mem_clr   <= w_mem_clr;
        end
    end

    // Request latch is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept && !clear) begin
            r_wr   <= req_wr;
            r_addr <= req_addr;
            r_data <= req_data;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign mem_sel   = r_mem_sel;
    assign mem_rw    = r_mem_rw;
    assign mem_we    = r_mem_we;
    assign mem_din   = r_mem_din;
    assign mem_clr   = r_mem_clr;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Randomized bench for ram_seq_ctrl against a word-array model and a request-level reference.
// Honours RAM_WRITE_VERIFY_EN in the same way as the design.
module tb_ram_seq_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int DW    = 4;
`ifdef RAM_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic             clk;
    logic             clear;
    logic             req_valid;
    logic             req_ready;
    logic             req_wr;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_data;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rsp_err;
    logic [DEPTH-1:0] mem_sel;
    logic             mem_rw;
    logic             mem_we;
    logic [DW-1:0]    mem_din;
    logic [DW-1:0]    mem_dout;
    logic             mem_clr;

    ram_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_sel(mem_sel), .mem_rw(mem_rw), .mem_we(mem_we),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_clr(mem_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell array model: writes gated by sel&rw&we, unselected words read as 0.
    logic [DW-1:0] env_mem [DEPTH];
    logic          stuck;
    logic [DW-1:0] env_dout;

    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_clr) env_mem[i] <= '0;
            else if (mem_we && mem_rw && mem_sel[i]) env_mem[i] <= mem_din;
        end
    end

    always_comb begin
        env_dout = '0;
        for (int i = 0; i < DEPTH; i++)
            if (mem_sel[i]) env_dout = env_dout | env_mem[i];
        if (stuck) env_dout = 4'h8;
    end
    assign mem_dout = env_dout;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    logic [DW-1:0] gold [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("sel_onehot0", 32'($onehot0(mem_sel)), 1);
            if (mem_we) check("we_gated", 32'(mem_rw && $onehot(mem_sel)), 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input bit stuck_exp);
        bit            in_range;
        int            exp_lat;
        logic [DW-1:0] exp_data;
        bit            exp_err;
        logic [DEPTH-1:0] exp_sel;
        int            lat;
        int            w;
        bit            done;

        in_range = (int'(addr) < DEPTH);
        exp_sel  = in_range ? (DEPTH'(1) << addr) : '0;
        exp_lat  = !in_range ? 1 : ((wr && VFY) ? 4 : 3);
        exp_err  = 1'b0;
        exp_data = '0;
        if (!in_range) exp_err = 1'b1;
        else if (!wr) exp_data = gold[addr];
        else if (VFY && stuck_exp && data != 4'h8) begin
            exp_err  = 1'b1;
            exp_data = 4'h8;
        end

        w = 0;
        while (!req_ready && w < 10) begin
            tick();
            w++;
        end
        check("ready_wait", 32'(req_ready), 1);

        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_data  = data;
        tick();
        lat  = 1;
        done = 1'b0;
        while (!done) begin
            if (rsp_valid) begin
                req_valid = 1'b0;
                check("latency", lat, exp_lat);
                check("rsp_data", 32'(rsp_data), 32'(exp_data));
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                check("done_sel", 32'(mem_sel), 0);
                check("done_we_rw", 32'({mem_we, mem_rw}), 0);
                check("done_din", 32'(mem_din), 0);
                done = 1'b1;
            end else if (lat > 6) begin
                check("rsp_timeout", 0, 1);
                req_valid = 1'b0;
                done = 1'b1;
            end else begin
                check("busy_ready", 32'(req_ready), 0);
                if (!in_range) check("oor_sel", 32'(mem_sel), 0);
                else if (lat == 1) begin
                    check("setup_sel", 32'(mem_sel), 32'(exp_sel));
                    check("setup_rw", 32'(mem_rw), 32'(wr));
                    check("setup_din", 32'(mem_din), 32'(data));
                    check("setup_we", 32'(mem_we), 0);
                end else if (lat == 2) begin
                    check("strobe_sel", 32'(mem_sel), 32'(exp_sel));
                    check("strobe_rw", 32'(mem_rw), 32'(wr));
                    check("strobe_we", 32'(mem_we), 32'(wr));
                end else if (lat == 3) begin
                    check("verify_sel", 32'(mem_sel), 32'(exp_sel));
                    check("verify_rw_we", 32'({mem_rw, mem_we}), 0);
                end
                // Inputs outside IDLE must be ignored.
                req_valid = 1'($urandom);
                req_wr    = 1'($urandom);
                req_addr  = AW'($urandom);
                req_data  = DW'($urandom);
                tick();
                lat++;
            end
        end
        tick();
        check("pulse_len", 32'(rsp_valid), 0);
        check("hold_data", 32'(rsp_data), 32'(exp_data));
        check("hold_err", 32'(rsp_err), 32'(exp_err));
        check("idle_ready", 32'(req_ready), 1);
        if (wr && in_range) gold[addr] = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;

        clear = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
        stuck = 1'b0;
        for (int i = 0; i < DEPTH; i++) gold[i] = '0;

        tick(); tick();
        check("rst_clr", 32'(mem_clr), 1);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 0);
        check("rst_mem", 32'({mem_sel, mem_rw, mem_we, mem_din}), 0);
        clear = 1'b0;
        check("init_clr", 32'(mem_clr), 1);
        check("init_ready", 32'(req_ready), 0);
        tick();
        check("idle_clr", 32'(mem_clr), 0);
        check("idle_ready0", 32'(req_ready), 1);
        check("idle_mem", 32'({mem_sel, mem_rw, mem_we, mem_din}), 0);
        mon_en = 1'b1;

        do_req(1'b1, 3'd2, 4'b0011, 1'b0);
        do_req(1'b0, 3'd2, 4'b0000, 1'b0);
        do_req(1'b0, 3'd5, 4'b0000, 1'b0);
        do_req(1'b1, 3'd7, 4'hF, 1'b0);

`ifdef RAM_WRITE_VERIFY_EN
        stuck = 1'b1;
        do_req(1'b1, 3'd1, 4'hA, 1'b1);
        stuck = 1'b0;
`endif

        // Clear arriving during a write strobe.
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 3'd1; req_data = 4'h5;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_we", 32'(mem_we), 1);
        clear = 1'b1;
        tick();
        check("mid_we_off", 32'(mem_we), 0);
        check("mid_clr", 32'(mem_clr), 1);
        check("mid_rsp", 32'(rsp_valid), 0);
        tick();
        check("mid_rsp2", 32'(rsp_valid), 0);
        clear = 1'b0;
        check("mid_init", 32'({mem_clr, req_ready}), 32'(2'b10));
        tick();
        check("mid_idle", 32'({mem_clr, req_ready, rsp_valid}), 32'(3'b010));
        check("mid_rsp_zero", 32'({rsp_err, rsp_data}), 0);
        for (int i = 0; i < DEPTH; i++) gold[i] = '0;
        do_req(1'b0, 3'd1, 4'h0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = AW'($urandom_range(0, 7));
            data = DW'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            do_req(wr, addr, data, 1'b0);
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
